i2s_rx: RTL
===========

# i2s_rx

Serial-to-parallel I2S receiver: the input-side counterpart of the board's I2S audio transmitter. It takes an external bit clock, word-select and serial data stream (Philips I2S framing, MSB first, one-bit delay after word-select change), oversamples them on the system clock, and presents each completed stereo pair as coherent 16-bit left/right words with a one-cycle valid strobe. It sits between an external ADC or codec (or a loopback of our own transmitter) and the audio mixer.

## Interface
- No parameters. Sample width is fixed at 16 bits.
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- ck  input  1  I2S bit clock, asynchronous to clock
- lr  input  1  I2S word select, 0 = left, 1 = right; asynchronous
- d  input  1  I2S serial data, MSB first; asynchronous
- l  output  16  last complete left sample
- r  output  16  last complete right sample
- valid  output  1  one-cycle pulse when l/r update with a new pair
- err  output  1  one-cycle pulse on a short (truncated) word

## Operation
- ck, lr and d each pass through a 2-flop synchronizer. A third flop on ck gives the edge detector: rise = ck_s2 & ~ck_s3. lr and d are sampled from their s2 stage only on cycles where rise = 1.
- Reset values: all synchronizer flops 0, l = 0, r = 0, valid = 0, err = 0, shift register 0, bit count 0, left-pending flag 0, state SYNC.
- The state machine advances only on rise cycles. valid and err are 0 on every other cycle.
- SYNC: on the first rise, store lr in lr_prev and go to WAIT. No data is captured.
- WAIT: on each rise, if lr != lr_prev, store lr into lr_prev and chan, clear the bit count, and go to SHIFT. The bit on that same edge is the previous word's trailing bit and is ignored.
- SHIFT: on each rise:
  - If lr == lr_prev: shift d into the LSB of the 16-bit shift register and increment the count.
  - When the count reaches 16, latch the word and go to WAIT. Any further bits in the slot (e.g. padding in 32-bit slots) are ignored.
- SHIFT, lr != lr_prev before 16 bits are received:
  - Pulse err.
  - Discard the partial word and clear left-pending.
  - Restart SHIFT for the new channel, using the same rules as the WAIT transition.
- Latch, chan = 0: copy the word to an internal left staging register and set left-pending.
- Latch, chan = 1 with left-pending = 1:
  - l <= staging register, r <= word.
  - Pulse valid and clear left-pending.
  - l and r always change together, so downstream never sees a mixed pair.
- Latch, chan = 1 with left-pending = 0: discard the word. Outputs and valid are unchanged. This covers start-up in a right slot and a pair broken by err.
- Reset mid-word returns to SYNC. The next output requires a fresh lr transition and a full left word, then a full right word.

## Timing
- Pin-to-rise detection latency: 3 clock cycles (2 synchronizer stages plus edge register).
- l, r and valid update on the clock edge that ends the rise cycle of the 16th right-channel bit. That is 3 cycles after the corresponding ck pin edge.
- err asserts on the edge ending the rise cycle where the early lr change is seen.
- ck high and low phases must each last ≥ 3 clock periods. The transmitter's 16-cycle phases give a 32-cycle bit period.
- d and lr must be stable for ≥ 3 clock cycles before and after each ck rising edge. The transmitter changes them at the opposite ck edge, which satisfies this.
- Throughput: one pair per lr period. valid is never asserted on two consecutive cycles.

## Test plan
- Reset behaviour: assert reset with ck toggling → l = 0, r = 0, valid = 0, err = 0. After release, no valid until a full left and a full right word are received.
- Nominal pair: ck period 32 clocks, 32-bit slots, left = 16'hA55A, right = 16'h1234, LSBs followed by zero padding → exactly one valid pulse 3 cycles after the 16th right-bit ck rise, with l = 16'hA55A and r = 16'h1234. Padding bits do not change the values.
- Loopback: transmitter output wired to the inputs, driven with l = 16'h8001 and r = 16'h7FFE → after the first complete pair, every valid presents l = 16'h8001 and r = 16'h7FFE. Exactly one valid per 1024-clock frame.
- Short word: left slot carries only 10 bits before lr rises → err pulses once, that frame produces no valid, and the next full frame yields a correct pair.
- Start in right slot: release reset mid-right-word → the first right word is discarded. The first valid carries the following left word and right word.
- Reset mid-word: assert reset during bit 8 of a left word → outputs return to 0. Recovery follows the start-up rules in the reset-behaviour scenario.

Source files
------------

// File: rtl/i2s_rx_if.sv
// I2S receiver port bundle: serial pins towards the receiver, parallel
// stereo pair plus strobes back out.
interface i2s_rx_if;
   logic        ck;
   logic        lr;
   logic        d;
   logic [15:0] l;
   logic [15:0] r;
   logic        valid;
   logic        err;

   modport master (output ck, lr, d, input l, r, valid, err);
   modport slave  (input ck, lr, d, output l, r, valid, err);
endinterface

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples ck/lr/d on the system clock and presents
// each completed left/right pair as one coherent update with a valid strobe.
module i2s_rx (
   input  logic      clock,
   input  logic      reset,
   i2s_rx_if.slave   bus
);
   typedef enum logic [1:0] {SYNC, WAIT, SHIFT} state_t;

   logic        r_ck_s1, r_ck_s2, r_ck_s3;
   logic        r_lr_s1, r_lr_s2;
   logic        r_d_s1, r_d_s2;
   state_t      r_state;
   logic        r_lr_prev, r_chan, r_pend;
   logic [15:0] r_shift, r_stage, r_l, r_r;
   logic [4:0]  r_cnt;
   logic        r_valid, r_err;

   state_t      w_state_next;
   logic        w_lr_prev_next, w_chan_next, w_pend_next;
   logic [15:0] w_shift_next, w_stage_next, w_l_next, w_r_next;
   logic [4:0]  w_cnt_next;
   logic        w_valid_next, w_err_next;
   logic        w_rise;
   logic [15:0] w_word;

   assign w_rise = r_ck_s2 & ~r_ck_s3;
   assign w_word = {r_shift[14:0], r_d_s2};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ck_s1   <= 1'b0;
         r_ck_s2   <= 1'b0;
         r_ck_s3   <= 1'b0;
         r_lr_s1   <= 1'b0;
         r_lr_s2   <= 1'b0;
         r_d_s1    <= 1'b0;
         r_d_s2    <= 1'b0;
         r_state   <= SYNC;
         r_lr_prev <= 1'b0;
         r_chan    <= 1'b0;
         r_pend    <= 1'b0;
         r_shift   <= 16'd0;
         r_stage   <= 16'd0;
         r_cnt     <= 5'd0;
         r_l       <= 16'd0;
         r_r       <= 16'd0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ck_s1   <= bus.ck;
         r_ck_s2   <= r_ck_s1;
         r_ck_s3   <= r_ck_s2;
         r_lr_s1   <= bus.lr;
         r_lr_s2   <= r_lr_s1;
         r_d_s1    <= bus.d;
         r_d_s2    <= r_d_s1;
         r_state   <= w_state_next;
         r_lr_prev <= w_lr_prev_next;
         r_chan    <= w_chan_next;
         r_pend    <= w_pend_next;
         r_shift   <= w_shift_next;
         r_stage   <= w_stage_next;
         r_cnt     <= w_cnt_next;
         r_l       <= w_l_next;
         r_r       <= w_r_next;
         r_valid   <= w_valid_next;
         r_err     <= w_err_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_lr_prev_next = r_lr_prev;
      w_chan_next    = r_chan;
      w_pend_next    = r_pend;
      w_shift_next   = r_shift;
      w_stage_next   = r_stage;
      w_cnt_next     = r_cnt;
      w_l_next       = r_l;
      w_r_next       = r_r;
      w_valid_next   = 1'b0;
      w_err_next     = 1'b0;
      if (w_rise) begin
         case (r_state)
            SYNC: begin
               w_lr_prev_next = r_lr_s2;
               w_state_next   = WAIT;
            end
            WAIT: begin
               // The bit on the lr-change edge is the old word's trailing bit.
               if (r_lr_s2 != r_lr_prev) begin
                  w_lr_prev_next = r_lr_s2;
                  w_chan_next    = r_lr_s2;
                  w_cnt_next     = 5'd0;
                  w_state_next   = SHIFT;
               end
            end
            SHIFT: begin
               if (r_lr_s2 != r_lr_prev) begin
                  w_err_next     = 1'b1;
                  w_pend_next    = 1'b0;
                  w_lr_prev_next = r_lr_s2;
                  w_chan_next    = r_lr_s2;
                  w_cnt_next     = 5'd0;
               end else begin
                  w_shift_next = w_word;
                  w_cnt_next   = r_cnt + 5'd1;
                  if (r_cnt == 5'd15) begin
                     w_state_next = WAIT;
                     if (!r_chan) begin
                        w_stage_next = w_word;
                        w_pend_next  = 1'b1;
                     end else if (r_pend) begin
                        // l and r move together so a pair is never mixed.
                        w_l_next     = r_stage;
                        w_r_next     = w_word;
                        w_valid_next = 1'b1;
                        w_pend_next  = 1'b0;
                     end
                  end
               end
            end
            default: w_state_next = SYNC;
         endcase
      end
   end

   assign bus.l     = r_l;
   assign bus.r     = r_r;
   assign bus.valid = r_valid;
   assign bus.err   = r_err;
endmodule
